// File: rtl/usb_in_arbiter.sv
// usb_in_arbiter: round-robin arbiter sharing the usb_cdc IN byte stream among NUM_REQ sources.
// Optional feature: define IN_ARB_TAG_EN to prefix every burst with a tag byte 8'hA0|port.
module usb_in_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BURST_LEN    = 8,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 configured_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [7:0]           out_data_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 busy_o
);

  localparam int          IW         = $clog2(NUM_REQ);
  localparam int unsigned NUM_U      = NUM_REQ;
  localparam logic [7:0]  BURST_LAST = 8'(BURST_LEN - 1);
  localparam logic [7:0]  IDLE_LAST  = 8'(IDLE_TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_INIT = IW'(NUM_REQ - 1);

`ifdef IN_ARB_TAG_EN
  typedef enum logic [1:0] {IDLE, TAG, BURST} state_t;
`else
  typedef enum logic [1:0] {IDLE, BURST} state_t;
`endif

  state_t        state;
  logic [IW-1:0] gnt;
  logic [IW-1:0] last;
  logic [IW-1:0] pick;
  logic          found;
  logic [7:0]    burst_cnt;
  logic [7:0]    idle_cnt;
  logic          xfer;
  logic [7:0]    src_data [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign src_data[k] = req_data_i[8*k +: 8];
  end

  // Search starts just after the previous winner so a re-requesting source yields to the others.
  always_comb begin
    int unsigned   idx;
    logic [IW-1:0] cand;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_U; i++) begin
      idx = 32'(last) + 1 + i;
      if (idx >= NUM_U) idx = idx - NUM_U;
      cand = IW'(idx);
      if (!found && req_valid_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    out_data_o  = '0;
    out_valid_o = 1'b0;
    req_ready_o = '0;
    case (state)
`ifdef IN_ARB_TAG_EN
      TAG: begin
        out_valid_o = 1'b1;
        out_data_o  = 8'hA0 | 8'(gnt);
      end
`endif
      BURST: begin
        out_valid_o      = req_valid_i[gnt];
        out_data_o       = req_valid_i[gnt] ? src_data[gnt] : '0;
        req_ready_o[gnt] = out_ready_i;
      end
      default: ;
    endcase
  end

  assign xfer   = out_valid_o & out_ready_i;
  assign busy_o = (state != IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      gnt       <= '0;
      last      <= LAST_INIT;
      grant_o   <= '0;
      burst_cnt <= '0;
      idle_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (configured_i && found) begin
            gnt     <= pick;
            grant_o <= NUM_REQ'(1) << pick;
`ifdef IN_ARB_TAG_EN
            state   <= TAG;
`else
            state   <= BURST;
`endif
          end
        end
`ifdef IN_ARB_TAG_EN
        TAG: begin
          if (!configured_i) begin
            state   <= IDLE;
            grant_o <= '0;
          end else if (xfer) begin
            state <= BURST;
          end
        end
`endif
        BURST: begin
          if (!configured_i) begin
            state     <= IDLE;
            grant_o   <= '0;
            burst_cnt <= '0;
            idle_cnt  <= '0;
          end else if (xfer) begin
            idle_cnt <= '0;
            if (burst_cnt == BURST_LAST) begin
              state     <= IDLE;
              grant_o   <= '0;
              last      <= gnt;
              burst_cnt <= '0;
            end else begin
              burst_cnt <= burst_cnt + 8'd1;
            end
          end else if (!req_valid_i[gnt]) begin
            if (idle_cnt == IDLE_LAST) begin
              state     <= IDLE;
              grant_o   <= '0;
              last      <= gnt;
              burst_cnt <= '0;
              idle_cnt  <= '0;
            end else begin
              idle_cnt <= idle_cnt + 8'd1;
            end
          end else begin
            idle_cnt <= '0;
          end
        end
        default: begin
          state   <= IDLE;
          grant_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_in_arbiter.sv
// Scoreboard bench for usb_in_arbiter: source queues feed the DUT, expected (grant, byte) pairs
// are queued when stimulus is loaded and retired as bytes appear on the output stream.
module tb_usb_in_arbiter;

`ifdef IN_ARB_TAG_EN
  localparam int TAGC = 1;
`else
  localparam int TAGC = 0;
`endif

  typedef struct {
    logic [3:0] grant;
    logic [7:0] data;
    bit         is_tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        configured;
  logic [31:0] req_data;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  grant;
  logic        busy;

  logic [7:0]  src_q [4][$];
  exp_t        exp_q [$];
  int          scnt [4];
  int          ecnt [4];
  int          n_checks = 0;
  int          n_pass   = 0;
  bit          chk_ready;
  logic [7:0]  abandon;
  int          n;

  usb_in_arbiter #(.NUM_REQ(4), .BURST_LEN(8), .IDLE_TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst), .configured_i(configured),
    .req_data_i(req_data), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .grant_o(grant), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
  endtask

  function automatic logic [7:0] val(input int p, input int i);
    return 8'(8'h11 * (p + 1) + i * 3);
  endfunction

  task automatic src_add(input int p, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      src_q[p].push_back(val(p, scnt[p]));
      scnt[p]++;
    end
  endtask

  task automatic exp_add(input int p, input int cnt);
    exp_t e;
    e.grant = 4'(1 << p);
    if (TAGC == 1) begin
      e.data   = 8'hA0 | 8'(p);
      e.is_tag = 1'b1;
      exp_q.push_back(e);
    end
    e.is_tag = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      e.data = val(p, ecnt[p]);
      ecnt[p]++;
      exp_q.push_back(e);
    end
  endtask

  task automatic drive();
    for (int p = 0; p < 4; p++) begin
      req_valid[p]        = (src_q[p].size() != 0);
      req_data[8*p +: 8]  = req_valid[p] ? src_q[p][0] : 8'h00;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input string tag, input int max, output int cyc);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < max) begin
      tick();
      cyc++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    chk_ready = 1'b0;
    for (int p = 0; p < 4; p++) src_q[p].delete();
    exp_q.delete();
    #1;
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_ready", req_ready, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Source/sink model: new loads appear at the falling edge, handshakes retire at the rising edge.
  initial begin
    logic [3:0] hs;
    logic [3:0] want_ready;
    exp_t       e;
    req_valid = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      drive();
      #1;
      hs = '0;
      if (!rst) begin
        if (out_valid && !configured) begin
          check("abandon_data", out_data, abandon);
        end else if (out_valid) begin
          if (exp_q.size() == 0) begin
            check("spurious_valid", out_valid, 0);
          end else begin
            e = exp_q[0];
            check("out_data", out_data, e.data);
            check("out_grant", grant, e.grant);
            if (chk_ready) begin
              want_ready = (e.is_tag || !out_ready) ? 4'b0000 : e.grant;
              check("req_ready", req_ready, want_ready);
            end
            if (out_ready) void'(exp_q.pop_front());
          end
        end else begin
          check("data_zero", out_data, 0);
        end
        hs = req_valid & req_ready;
      end
      @(posedge clk);
      #1;
      for (int p = 0; p < 4; p++)
        if (hs[p] && src_q[p].size() != 0) void'(src_q[p].pop_front());
      drive();
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    configured = 1'b1;
    out_ready = 1'b1;
    chk_ready = 1'b0;
    abandon = '0;
    for (int p = 0; p < 4; p++) begin
      scnt[p] = 0;
      ecnt[p] = 0;
    end
    do_reset();

    // single source, short burst, then idle timeout
    src_add(2, 3);
    exp_add(2, 3);
    tick();
    check("t1_grant", grant, 4'b0100);
    check("t1_busy", busy, 1);
    wait_drain("t1_drain", 100, n);
    check("t1_cycles", n, TAGC + 3);
    repeat (15) tick();
    check("t1_busy_hold", busy, 1);
    tick();
    check("t1_timeout_busy", busy, 0);
    check("t1_timeout_grant", grant, 0);

    // all four ports contend: 0,1,2,3,0 with one arbitration cycle per burst
    do_reset();
    src_add(0, 16);
    for (int p = 1; p < 4; p++) src_add(p, 8);
    exp_add(0, 8);
    exp_add(1, 8);
    exp_add(2, 8);
    exp_add(3, 8);
    exp_add(0, 8);
    wait_drain("t2_drain", 200, n);
    check("t2_cycles", n, 5 * (9 + TAGC));

    // port 1 under backpressure; exactly 8 bytes before port 3 gets its turn
    do_reset();
    src_add(1, 9);
    src_add(3, 1);
    exp_add(1, 8);
    exp_add(3, 1);
    exp_add(1, 1);
    chk_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      out_ready = ~out_ready;
      n++;
    end
    check("t3_drain", exp_q.size(), 0);
    chk_ready = 1'b0;
    out_ready = 1'b1;
    repeat (20) tick();
    check("t3_idle", busy, 0);

    // unconfigured hold-off, mid-burst deconfigure, fresh burst on re-enable
    do_reset();
    configured = 1'b0;
    src_add(0, 11);
    repeat (5) tick();
    check("t4_unconf_grant", grant, 0);
    check("t4_unconf_busy", busy, 0);
    exp_add(0, 3);
    exp_add(0, 8);
    configured = 1'b1;
    n = 0;
    while (exp_q.size() > 8 + TAGC && n < 100) begin
      tick();
      n++;
    end
    check("t4_first3", exp_q.size(), 8 + TAGC);
    abandon = exp_q[TAGC].data;
    configured = 1'b0;
    out_ready = 1'b0;
    tick();
    check("t4_drop_valid", out_valid, 0);
    check("t4_drop_busy", busy, 0);
    check("t4_drop_grant", grant, 0);
    configured = 1'b1;
    out_ready = 1'b1;
    wait_drain("t4_drain", 100, n);
    check("t4_cycles", n, 9 + TAGC);

    // asynchronous reset in the middle of port 1's burst
    do_reset();
    src_add(0, 8);
    src_add(1, 8);
    exp_add(0, 8);
    exp_add(1, 8);
    n = 0;
    while (exp_q.size() > 5 && n < 100) begin
      tick();
      n++;
    end
    check("t5_midburst_busy", busy, 1);
    check("t5_midburst_grant", grant, 4'b0010);
    rst = 1'b1;
    #1;
    check("t5_async_grant", grant, 0);
    check("t5_async_busy", busy, 0);
    check("t5_async_valid", out_valid, 0);
    check("t5_async_data", out_data, 0);
    check("t5_async_ready", req_ready, 0);
    for (int p = 0; p < 4; p++) src_q[p].delete();
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    src_add(1, 2);
    src_add(0, 2);
    exp_add(0, 2);
    exp_add(1, 2);
    wait_drain("t5_drain", 100, n);
    check("t5_cycles", n, 22 + 2 * TAGC);

    // two-byte burst from port 1 (tag byte first when tagging is built in)
    do_reset();
    src_add(1, 2);
    exp_add(1, 2);
    wait_drain("t6_drain", 100, n);
    check("t6_cycles", n, 3 + TAGC);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
